// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, two response ports and the shared ALU link.
// The arbiter takes the slave view; requesters, consumers and the ALU take the master view.
interface alu_arbiter_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNT_W  = 16;

    logic              r0_valid;
    logic              r1_valid;
    logic              r0_ready;
    logic              r1_ready;
    logic [OP_W-1:0]   r0_op;
    logic [OP_W-1:0]   r1_op;
    logic [DATA_W-1:0] r0_a;
    logic [DATA_W-1:0] r0_b;
    logic [DATA_W-1:0] r1_a;
    logic [DATA_W-1:0] r1_b;

    logic              p0_rsp_valid;
    logic              p1_rsp_valid;
    logic              p0_rsp_ready;
    logic              p1_rsp_ready;
    logic [DATA_W-1:0] p0_result;
    logic [DATA_W-1:0] p1_result;
    logic              p0_zero;
    logic              p1_zero;

    logic [OP_W-1:0]   alu_ctrl;
    logic [DATA_W-1:0] alu_datain1;
    logic [DATA_W-1:0] alu_datain2;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;

    logic [CNT_W-1:0]  conflict_cnt;

    modport slave (
        input  r0_valid, r1_valid, r0_op, r1_op, r0_a, r0_b, r1_a, r1_b,
        input  p0_rsp_ready, p1_rsp_ready, alu_result, alu_zero,
        output r0_ready, r1_ready,
        output p0_rsp_valid, p1_rsp_valid, p0_result, p1_result, p0_zero, p1_zero,
        output alu_ctrl, alu_datain1, alu_datain2, conflict_cnt
    );

    modport master (
        output r0_valid, r1_valid, r0_op, r1_op, r0_a, r0_b, r1_a, r1_b,
        output p0_rsp_ready, p1_rsp_ready, alu_result, alu_zero,
        input  r0_ready, r1_ready,
        input  p0_rsp_valid, p1_rsp_valid, p0_result, p1_result, p0_zero, p1_zero,
        input  alu_ctrl, alu_datain1, alu_datain2, conflict_cnt
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU, with a one-deep
// response register per port and a saturating contention counter.
module alu_arbiter #(
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic clk,
    input  logic rst,
    alu_arbiter_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              elig0;
    logic              elig1;
    logic              contend;
    logic              grant0;
    logic              grant1;
    logic              last_grant;
    logic              rsp_valid0;
    logic              rsp_valid1;
    logic [DATA_W-1:0] result0;
    logic [DATA_W-1:0] result1;
    logic              zero0;
    logic              zero1;
    logic [CNT_W-1:0]  cnt;

    // A port may be granted when its slot is empty or being emptied this cycle.
    assign elig0   = bus.r0_valid && (!rsp_valid0 || bus.p0_rsp_ready);
    assign elig1   = bus.r1_valid && (!rsp_valid1 || bus.p1_rsp_ready);
    assign contend = elig0 && elig1;

    // last_grant = 1 means port 1 won last, so port 0 wins the next contention.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (contend) begin
                if ((PRIO_MODE != 32'd0) || last_grant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign bus.r0_ready = grant0;
    assign bus.r1_ready = grant1;

    // Operand steering to the shared ALU; idle cycles present all zeros.
    always_comb begin
        bus.alu_ctrl    = '0;
        bus.alu_datain1 = '0;
        bus.alu_datain2 = '0;
        if (grant0) begin
            bus.alu_ctrl    = bus.r0_op;
            bus.alu_datain1 = bus.r0_a;
            bus.alu_datain2 = bus.r0_b;
        end else if (grant1) begin
            bus.alu_ctrl    = bus.r1_op;
            bus.alu_datain1 = bus.r1_a;
            bus.alu_datain2 = bus.r1_b;
        end
    end

    // Response slots, grant history and contention counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            result0    <= '0;
            result1    <= '0;
            zero0      <= 1'b0;
            zero1      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            if (grant0) begin
                rsp_valid0 <= 1'b1;
                result0    <= bus.alu_result;
                zero0      <= bus.alu_zero;
            end else if (bus.p0_rsp_ready) begin
                rsp_valid0 <= 1'b0;
            end

            if (grant1) begin
                rsp_valid1 <= 1'b1;
                result1    <= bus.alu_result;
                zero1      <= bus.alu_zero;
            end else if (bus.p1_rsp_ready) begin
                rsp_valid1 <= 1'b0;
            end

            if (grant0) begin
                last_grant <= 1'b0;
            end else if (grant1) begin
                last_grant <= 1'b1;
            end

            if (contend && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.p0_rsp_valid = rsp_valid0;
    assign bus.p1_rsp_valid = rsp_valid1;
    assign bus.p0_result    = result0;
    assign bus.p1_result    = result1;
    assign bus.p0_zero      = zero0;
    assign bus.p1_zero      = zero1;
    assign bus.conflict_cnt = cnt;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin and one fixed-priority instance,
// each fronting a small behavioural ALU.
module tb_alu_arbiter;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    alu_arbiter_if bus_rr ();
    alu_arbiter_if bus_fp ();

    alu_arbiter #(.PRIO_MODE(0)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
    alu_arbiter #(.PRIO_MODE(1)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    assign bus_rr.alu_result = alu_model(bus_rr.alu_ctrl, bus_rr.alu_datain1, bus_rr.alu_datain2);
    assign bus_rr.alu_zero   = (bus_rr.alu_result == 32'd0);
    assign bus_fp.alu_result = alu_model(bus_fp.alu_ctrl, bus_fp.alu_datain1, bus_fp.alu_datain2);
    assign bus_fp.alu_zero   = (bus_fp.alu_result == 32'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic exp_g0 [4];

    initial begin
        errors = 0;
        checks = 0;
        exp_g0 = '{1'b1, 1'b0, 1'b1, 1'b0};
        rst = 1'b1;
        bus_rr.r0_valid = 1'b0; bus_rr.r1_valid = 1'b0;
        bus_rr.r0_op = '0; bus_rr.r1_op = '0;
        bus_rr.r0_a = '0; bus_rr.r0_b = '0; bus_rr.r1_a = '0; bus_rr.r1_b = '0;
        bus_rr.p0_rsp_ready = 1'b1; bus_rr.p1_rsp_ready = 1'b1;
        bus_fp.r0_valid = 1'b0; bus_fp.r1_valid = 1'b0;
        bus_fp.r0_op = '0; bus_fp.r1_op = '0;
        bus_fp.r0_a = '0; bus_fp.r0_b = '0; bus_fp.r1_a = '0; bus_fp.r1_b = '0;
        bus_fp.p0_rsp_ready = 1'b1; bus_fp.p1_rsp_ready = 1'b1;

        // Reset state, ready suppressed while in reset.
        #2;
        bus_rr.r0_valid = 1'b1;
        #1;
        check("rst_r0_ready", 32'(bus_rr.r0_ready), 32'd0);
        check("rst_p0_valid", 32'(bus_rr.p0_rsp_valid), 32'd0);
        check("rst_p0_result", bus_rr.p0_result, 32'd0);
        check("rst_cnt", 32'(bus_rr.conflict_cnt), 32'd0);
        bus_rr.r0_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        step();

        // Single request on port 0.
        bus_rr.r0_valid = 1'b1; bus_rr.r0_op = OP_ADD; bus_rr.r0_a = 32'd5; bus_rr.r0_b = 32'd7;
        #1;
        check("single_r0_ready", 32'(bus_rr.r0_ready), 32'd1);
        check("single_r1_ready", 32'(bus_rr.r1_ready), 32'd0);
        check("single_alu_ctrl", 32'(bus_rr.alu_ctrl), 32'(OP_ADD));
        check("single_alu_a", bus_rr.alu_datain1, 32'd5);
        step();
        bus_rr.r0_valid = 1'b0;
        check("single_p0_valid", 32'(bus_rr.p0_rsp_valid), 32'd1);
        check("single_p0_result", bus_rr.p0_result, 32'd12);
        check("single_p0_zero", 32'(bus_rr.p0_zero), 32'd0);
        #1;
        check("idle_alu_ctrl", 32'(bus_rr.alu_ctrl), 32'd0);
        check("idle_alu_a", bus_rr.alu_datain1, 32'd0);
        step();
        check("drain_p0_valid", 32'(bus_rr.p0_rsp_valid), 32'd0);

        // Lone port-1 request so port 0 is next in round-robin order.
        bus_rr.r1_valid = 1'b1; bus_rr.r1_op = OP_ADD; bus_rr.r1_a = 32'd2; bus_rr.r1_b = 32'd3;
        #1;
        check("single_r1_ready", 32'(bus_rr.r1_ready), 32'd1);
        step();
        check("single_p1_result", bus_rr.p1_result, 32'd5);

        // Four cycles of contention: grants alternate 0,1,0,1.
        bus_rr.r0_valid = 1'b1; bus_rr.r0_op = OP_SUB; bus_rr.r0_a = 32'd9; bus_rr.r0_b = 32'd9;
        bus_rr.r1_valid = 1'b1; bus_rr.r1_op = OP_XOR; bus_rr.r1_a = 32'd3; bus_rr.r1_b = 32'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_r0_ready_%0d", i), 32'(bus_rr.r0_ready), 32'(exp_g0[i]));
            check($sformatf("rr_r1_ready_%0d", i), 32'(bus_rr.r1_ready), 32'(!exp_g0[i]));
            step();
        end
        bus_rr.r0_valid = 1'b0; bus_rr.r1_valid = 1'b0;
        check("rr_p0_result", bus_rr.p0_result, 32'd0);
        check("rr_p0_zero", 32'(bus_rr.p0_zero), 32'd1);
        check("rr_p1_result", bus_rr.p1_result, 32'd2);
        check("rr_p1_zero", 32'(bus_rr.p1_zero), 32'd0);
        check("rr_cnt", 32'(bus_rr.conflict_cnt), 32'd4);
        step();

        // Backpressure on port 0, then drain and new grant on one edge.
        bus_rr.p0_rsp_ready = 1'b0;
        bus_rr.r0_valid = 1'b1; bus_rr.r0_op = OP_ADD; bus_rr.r0_a = 32'd10; bus_rr.r0_b = 32'd20;
        step();
        check("bp_p0_valid", 32'(bus_rr.p0_rsp_valid), 32'd1);
        check("bp_p0_result", bus_rr.p0_result, 32'd30);
        bus_rr.r0_a = 32'd1; bus_rr.r0_b = 32'd1;
        #1;
        check("bp_r0_ready", 32'(bus_rr.r0_ready), 32'd0);
        step();
        check("bp_hold_result", bus_rr.p0_result, 32'd30);
        check("bp_hold_valid", 32'(bus_rr.p0_rsp_valid), 32'd1);
        bus_rr.p0_rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus_rr.r0_ready), 32'd1);
        step();
        check("bp_reload_valid", 32'(bus_rr.p0_rsp_valid), 32'd1);
        check("bp_reload_result", bus_rr.p0_result, 32'd2);
        bus_rr.r0_valid = 1'b0;
        step();
        check("bp_final_drain", 32'(bus_rr.p0_rsp_valid), 32'd0);

        // Reset while port 1 holds a response.
        bus_rr.p1_rsp_ready = 1'b0;
        bus_rr.r1_valid = 1'b1; bus_rr.r1_op = OP_OR; bus_rr.r1_a = 32'd4; bus_rr.r1_b = 32'd8;
        step();
        bus_rr.r1_valid = 1'b0;
        check("mid_p1_valid", 32'(bus_rr.p1_rsp_valid), 32'd1);
        check("mid_p1_result", bus_rr.p1_result, 32'd12);
        rst = 1'b1;
        #1;
        check("mid_rst_p1_valid", 32'(bus_rr.p1_rsp_valid), 32'd0);
        check("mid_rst_p1_result", bus_rr.p1_result, 32'd0);
        check("mid_rst_cnt", 32'(bus_rr.conflict_cnt), 32'd0);
        bus_rr.p1_rsp_ready = 1'b1;
        step();
        @(negedge clk) rst = 1'b0;
        step();
        bus_rr.r0_valid = 1'b1; bus_rr.r0_op = OP_AND; bus_rr.r0_a = 32'hF0; bus_rr.r0_b = 32'h3C;
        bus_rr.r1_valid = 1'b1;
        #1;
        check("post_rst_r0_ready", 32'(bus_rr.r0_ready), 32'd1);
        check("post_rst_r1_ready", 32'(bus_rr.r1_ready), 32'd0);
        step();
        check("post_rst_p0_result", bus_rr.p0_result, 32'h30);
        check("post_rst_cnt", 32'(bus_rr.conflict_cnt), 32'd1);
        bus_rr.r0_valid = 1'b0; bus_rr.r1_valid = 1'b0;
        step();

        // Fixed priority: port 0 wins every contended cycle.
        bus_fp.r0_valid = 1'b1; bus_fp.r0_op = OP_ADD; bus_fp.r0_a = 32'd1; bus_fp.r0_b = 32'd1;
        bus_fp.r1_valid = 1'b1; bus_fp.r1_op = OP_ADD; bus_fp.r1_a = 32'd2; bus_fp.r1_b = 32'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("fp_r0_ready_%0d", i), 32'(bus_fp.r0_ready), 32'd1);
            check($sformatf("fp_r1_ready_%0d", i), 32'(bus_fp.r1_ready), 32'd0);
            step();
        end
        bus_fp.r0_valid = 1'b0; bus_fp.r1_valid = 1'b0;
        check("fp_p0_result", bus_fp.p0_result, 32'd2);
        check("fp_p1_valid", 32'(bus_fp.p1_rsp_valid), 32'd0);
        check("fp_cnt", 32'(bus_fp.conflict_cnt), 32'd3);

        // Saturation of the contention counter (starts at 1 here).
        bus_rr.r0_valid = 1'b1; bus_rr.r1_valid = 1'b1;
        repeat (65533) @(posedge clk);
        #1;
        check("sat_fffe", 32'(bus_rr.conflict_cnt), 32'h0000FFFE);
        step();
        check("sat_ffff", 32'(bus_rr.conflict_cnt), 32'h0000FFFF);
        repeat (5) @(posedge clk);
        #1;
        check("sat_hold", 32'(bus_rr.conflict_cnt), 32'h0000FFFF);
        bus_rr.r0_valid = 1'b0; bus_rr.r1_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
